// File: rtl/hub75_panel_sink.sv
// Panel-side HUB75 receiver: samples the panel bus, shifts columns, latches rows
// into a 32x32 RGB frame store and reports OE timing, frame count and shift errors.
module hub75_panel_sink #(
    parameter int WIDTH   = 32,
    parameter int OE_BITS = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               PANEL_R0,
    input  logic               PANEL_G0,
    input  logic               PANEL_B0,
    input  logic               PANEL_R1,
    input  logic               PANEL_G1,
    input  logic               PANEL_B1,
    input  logic               PANEL_A,
    input  logic               PANEL_B,
    input  logic               PANEL_C,
    input  logic               PANEL_D,
    input  logic               PANEL_CLK,
    input  logic               PANEL_STB,
    input  logic               PANEL_OE,
    input  logic [4:0]         rd_x,
    input  logic [4:0]         rd_y,
    output logic [2:0]         rd_rgb,
    output logic               frame_pulse,
    output logic [7:0]         frame_cnt,
    output logic [3:0]         row_last,
    output logic [OE_BITS-1:0] oe_cycles,
    output logic               err_shift,
    input  logic               err_clr
);

    localparam int                 ROW_BITS = 3 * WIDTH;
    localparam logic [5:0]         CNT_MAX  = 6'd63;
    localparam logic [5:0]         CNT_FULL = 6'(WIDTH);
    localparam logic [OE_BITS-1:0] OE_ONE   = OE_BITS'(1);
    localparam logic [OE_BITS-1:0] OE_MAX   = '1;

    // ------------------------------------------------------------------
    // Input sampling stage and edge history
    // ------------------------------------------------------------------
    logic [5:0] pix_q;        // {R1,G1,B1,R0,G0,B0}
    logic [3:0] addr_q;       // {D,C,B,A}
    logic       pclk_q;
    logic       pclk_prev_q;
    logic       stb_q;
    logic       stb_prev_q;
    logic       oe_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_q       <= '0;
            addr_q      <= '0;
            pclk_q      <= 1'b0;
            pclk_prev_q <= 1'b0;
            stb_q       <= 1'b0;
            stb_prev_q  <= 1'b0;
            oe_q        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let the previous-sample registers
            // capture the pre-edge value of the sample registers.
            pix_q       <= {PANEL_R1, PANEL_G1, PANEL_B1, PANEL_R0, PANEL_G0, PANEL_B0};
            addr_q      <= {PANEL_D, PANEL_C, PANEL_B, PANEL_A};
            pclk_q      <= PANEL_CLK;
            pclk_prev_q <= pclk_q;
            stb_q       <= PANEL_STB;
            stb_prev_q  <= stb_q;
            oe_q        <= PANEL_OE;
        end
    end

    logic clk_rise;
    logic stb_rise;

    assign clk_rise = pclk_q & ~pclk_prev_q;
    assign stb_rise = stb_q & ~stb_prev_q;

    // ------------------------------------------------------------------
    // Column shift register: new pixel enters at WIDTH-1, drifts toward 0
    // ------------------------------------------------------------------
    logic [5:0] sr_q [WIDTH];
    logic [5:0] sr_d [WIDTH];

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            sr_d[i] = sr_q[i];
        end
        if (clk_rise) begin
            for (int i = 0; i < WIDTH - 1; i++) begin
                sr_d[i] = sr_q[i + 1];
            end
            sr_d[WIDTH - 1] = pix_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WIDTH; i++) begin
                sr_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                sr_q[i] <= sr_d[i];
            end
        end
    end

    // Row words for the two panel halves, taken from the pre-shift contents
    logic [ROW_BITS-1:0] top_row;
    logic [ROW_BITS-1:0] bot_row;

    always_comb begin
        top_row = '0;
        bot_row = '0;
        for (int c = 0; c < WIDTH; c++) begin
            top_row[3*c +: 3] = sr_q[c][2:0];
            bot_row[3*c +: 3] = sr_q[c][5:3];
        end
    end

    // ------------------------------------------------------------------
    // Frame store: two 16-row halves written together on a latch
    // ------------------------------------------------------------------
    logic [ROW_BITS-1:0] top_mem [16];
    logic [ROW_BITS-1:0] bot_mem [16];

    // NOTE: the frame store has no reset so it can map onto plain RAM;
    // its contents are undefined until a row is latched.
    always_ff @(posedge clk) begin
        if (stb_rise) begin
            top_mem[addr_q] <= top_row;
            bot_mem[addr_q] <= bot_row;
        end
    end

    // ------------------------------------------------------------------
    // Latch bookkeeping: shift count, OE timing, row/frame tracking, errors
    // ------------------------------------------------------------------
    logic [5:0]         cnt_q,         cnt_d;
    logic [OE_BITS-1:0] oe_run_q,      oe_run_d;
    logic [OE_BITS-1:0] oe_cycles_q,   oe_cycles_d;
    logic [3:0]         row_last_q,    row_last_d;
    logic               first_q,       first_d;
    logic [7:0]         frame_cnt_q,   frame_cnt_d;
    logic               frame_pulse_q, frame_pulse_d;
    logic               err_q,         err_d;
    logic [OE_BITS-1:0] oe_run_inc;

    assign oe_run_inc = (!oe_q && oe_run_q != OE_MAX) ? oe_run_q + OE_ONE : oe_run_q;

    always_comb begin
        // NOTE: every next-state signal gets a default first, so no latches.
        cnt_d         = cnt_q;
        oe_run_d      = oe_run_inc;
        oe_cycles_d   = oe_cycles_q;
        row_last_d    = row_last_q;
        first_d       = first_q;
        frame_cnt_d   = frame_cnt_q;
        frame_pulse_d = 1'b0;
        err_d         = err_q;

        if (clk_rise && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 6'd1;
        end

        if (err_clr) begin
            err_d = 1'b0;
        end

        if (stb_rise) begin
            // A coincident shift counts as the first pixel of the next row
            cnt_d       = clk_rise ? 6'd1 : 6'd0;
            oe_cycles_d = oe_run_inc;
            oe_run_d    = '0;
            row_last_d  = addr_q;
            first_d     = 1'b0;
            if (cnt_q != CNT_FULL) begin
                err_d = 1'b1;
            end
            if (addr_q == 4'd0 && row_last_q == 4'd15 && !first_q) begin
                frame_pulse_d = 1'b1;
                frame_cnt_d   = frame_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q         <= '0;
            oe_run_q      <= '0;
            oe_cycles_q   <= '0;
            row_last_q    <= 4'd15;
            first_q       <= 1'b1;
            frame_cnt_q   <= '0;
            frame_pulse_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            oe_run_q      <= oe_run_d;
            oe_cycles_q   <= oe_cycles_d;
            row_last_q    <= row_last_d;
            first_q       <= first_d;
            frame_cnt_q   <= frame_cnt_d;
            frame_pulse_q <= frame_pulse_d;
            err_q         <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Registered read port
    // ------------------------------------------------------------------
    logic [ROW_BITS-1:0] rd_word;
    logic [2:0]          rd_pix;
    logic [2:0]          rd_rgb_q;

    always_comb begin
        rd_word = rd_y[4] ? bot_mem[rd_y[3:0]] : top_mem[rd_y[3:0]];
        rd_pix  = 3'b000;
        for (int c = 0; c < WIDTH; c++) begin
            if (rd_x == 5'(c)) begin
                rd_pix = rd_word[3*c +: 3];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_rgb_q <= '0;
        end else begin
            rd_rgb_q <= rd_pix;
        end
    end

    assign rd_rgb      = rd_rgb_q;
    assign frame_pulse = frame_pulse_q;
    assign frame_cnt   = frame_cnt_q;
    assign row_last    = row_last_q;
    assign oe_cycles   = oe_cycles_q;
    assign err_shift   = err_q;

endmodule

// File: tb/tb_hub75_panel_sink.sv
// Self-checking bench for hub75_panel_sink: table-driven reads, hand sequences for
// the multi-cycle corners and randomized rows against a pixel-history model.
module tb_hub75_panel_sink;

    localparam int WIDTH   = 32;
    localparam int OE_BITS = 8;

    logic clk = 1'b0;
    logic rst;
    logic r0, g0, b0, r1, g1, b1;
    logic pa, pb, pc, pd;
    logic pclk, pstb, poe;
    logic err_clr;
    logic [4:0] rd_x, rd_y;
    logic [2:0] rd_rgb;
    logic frame_pulse;
    logic [7:0] frame_cnt;
    logic [3:0] row_last;
    logic [OE_BITS-1:0] oe_cycles;
    logic err_shift;

    hub75_panel_sink #(.WIDTH(WIDTH), .OE_BITS(OE_BITS)) dut (
        .clk(clk), .rst(rst),
        .PANEL_R0(r0), .PANEL_G0(g0), .PANEL_B0(b0),
        .PANEL_R1(r1), .PANEL_G1(g1), .PANEL_B1(b1),
        .PANEL_A(pa), .PANEL_B(pb), .PANEL_C(pc), .PANEL_D(pd),
        .PANEL_CLK(pclk), .PANEL_STB(pstb), .PANEL_OE(poe),
        .rd_x(rd_x), .rd_y(rd_y), .rd_rgb(rd_rgb),
        .frame_pulse(frame_pulse), .frame_cnt(frame_cnt), .row_last(row_last),
        .oe_cycles(oe_cycles), .err_shift(err_shift), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int pulse_cnt = 0;

    always @(negedge clk) if (frame_pulse === 1'b1) pulse_cnt++;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    logic [5:0] hist[$];          // every pixel ever shifted since reset
    logic [2:0] m_pix [32][32];   // [y][x]
    int   m_cnt;
    logic m_err;
    int   m_row_last;
    bit   m_first;
    int   m_frames;

    function automatic void model_reset();
        hist.delete();
        for (int i = 0; i < WIDTH; i++) hist.push_back(6'd0);
        m_cnt = 0; m_err = 1'b0; m_row_last = 15; m_first = 1'b1; m_frames = 0;
    endfunction

    function automatic void model_shift(input logic [5:0] px);
        hist.push_back(px);
        if (hist.size() > 2 * WIDTH) void'(hist.pop_front());
        if (m_cnt < 63) m_cnt++;
    endfunction

    function automatic void model_latch(input int row);
        logic [5:0] px;
        for (int c = 0; c < WIDTH; c++) begin
            px = hist[hist.size() - WIDTH + c];
            m_pix[row][c]      = px[2:0];
            m_pix[row + 16][c] = px[5:3];
        end
        if (m_cnt != WIDTH) m_err = 1'b1;
        if (row == 0 && m_row_last == 15 && !m_first) m_frames++;
        m_first = 1'b0;
        m_row_last = row;
        m_cnt = 0;
    endfunction

    function automatic logic [5:0] pattern_px(input int r, input int c);
        logic [5:0] px;
        px[2] = (c == r);
        px[1] = (c == 31 - r);
        px[0] = (c == 15 || c == 16);
        px[5] = (c == r + 16);
        px[4] = (c == 15 - r);
        px[3] = (c == 15 || c == 16);
        return px;
    endfunction

    // ---------------- drivers and checks ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse(input logic [5:0] px);
        {r1, g1, b1, r0, g0, b0} = px;
        pclk = 1'b0; tick();
        pclk = 1'b1; tick();
        pclk = 1'b0;
        model_shift(px);
    endtask

    task automatic latch(input int row);
        logic [3:0] a;
        a = 4'(row);
        {pd, pc, pb, pa} = a;
        pstb = 1'b1; tick();
        pstb = 1'b0; tick();
        model_latch(row);
    endtask

    task automatic clear_err();
        err_clr = 1'b1; tick();
        err_clr = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic read_chk(input string name, input int x, input int y, input logic [2:0] exp);
        rd_x = 5'(x); rd_y = 5'(y);
        tick();
        check(name, 32'(rd_rgb), 32'(exp));
    endtask

    task automatic row_chk(input string name, input int row);
        for (int h = 0; h < 2; h++)
            for (int x = 0; x < WIDTH; x++)
                read_chk(name, x, row + 16 * h, m_pix[row + 16 * h][x]);
    endtask

    task automatic do_reset();
        rst = 1'b1; tick(); tick();
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic [4:0] x;
        logic [4:0] y;
        logic [2:0] rgb;
    } rd_vec_t;

    rd_vec_t vecs[8];

    initial begin
        int p0;
        logic [5:0] d;
        vecs[0] = '{5'd5,  5'd3,  3'b100};
        vecs[1] = '{5'd20, 5'd19, 3'b001};
        vecs[2] = '{5'd4,  5'd3,  3'b000};
        vecs[3] = '{5'd6,  5'd3,  3'b000};
        vecs[4] = '{5'd5,  5'd19, 3'b000};
        vecs[5] = '{5'd20, 5'd3,  3'b000};
        vecs[6] = '{5'd0,  5'd3,  3'b000};
        vecs[7] = '{5'd31, 5'd19, 3'b000};

        rst = 1'b1;
        {r1, g1, b1, r0, g0, b0} = '0;
        {pd, pc, pb, pa} = '0;
        pclk = 1'b0; pstb = 1'b0; poe = 1'b1; err_clr = 1'b0;
        rd_x = '0; rd_y = '0;
        repeat (3) tick();
        check("reset_rd_rgb", 32'(rd_rgb), 0);
        check("reset_frame_pulse", 32'(frame_pulse), 0);
        check("reset_frame_cnt", 32'(frame_cnt), 0);
        check("reset_row_last", 32'(row_last), 15);
        check("reset_oe_cycles", 32'(oe_cycles), 0);
        check("reset_err", 32'(err_shift), 0);
        rst = 1'b0;
        model_reset();
        tick();

        // Single row: R0 at column 5, B1 at column 20, latched to row 3
        for (int c = 0; c < WIDTH; c++)
            pulse(c == 5 ? 6'b000100 : (c == 20 ? 6'b001000 : 6'b000000));
        latch(3);
        check("single_err", 32'(err_shift), 0);
        check("single_row_last", 32'(row_last), 3);
        for (int i = 0; i < 8; i++) read_chk("single_vec", vecs[i].x, vecs[i].y, vecs[i].rgb);
        row_chk("single_row", 3);

        // Short row, clear, clean row
        for (int c = 0; c < WIDTH - 1; c++) pulse(6'($urandom));
        latch(5);
        check("short_err", 32'(err_shift), 32'(m_err));
        clear_err();
        check("clr_err", 32'(err_shift), 0);
        for (int c = 0; c < WIDTH; c++) pulse(6'($urandom));
        latch(6);
        check("clean_err", 32'(err_shift), 0);
        row_chk("clean_row", 6);

        // OE timing
        latch(1);
        poe = 1'b0; repeat (29) tick(); poe = 1'b1;
        latch(1);
        check("oe_29", 32'(oe_cycles), 29);
        poe = 1'b0; repeat (300) tick(); poe = 1'b1;
        latch(1);
        check("oe_sat", 32'(oe_cycles), 255);
        poe = 1'b0; repeat (10) tick();
        latch(1);
        poe = 1'b1;
        check("oe_incl_latch_cycle", 32'(oe_cycles), 11);
        check("oe_err_model", 32'(err_shift), 32'(m_err));

        // Set beats clear in the same cycle
        clear_err();
        for (int c = 0; c < WIDTH - 1; c++) pulse(6'($urandom));
        err_clr = 1'b1;
        latch(8);
        err_clr = 1'b0;
        check("set_wins_err", 32'(err_shift), 1);

        // Frame wrap: random first pass, loopback pattern second pass
        do_reset();
        p0 = pulse_cnt;
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < WIDTH; c++) pulse(6'($urandom));
            latch(r);
        end
        check("no_pulse_first_frame", 32'(pulse_cnt - p0), 0);
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < WIDTH; c++) pulse(pattern_px(r, c));
            latch(r);
            if (r == 0) check("wrap_pulse", 32'(frame_pulse), 1);
        end
        check("wrap_pulse_count", 32'(pulse_cnt - p0), 1);
        check("wrap_frame_cnt", 32'(frame_cnt), 1);
        check("loop_err", 32'(err_shift), 0);
        for (int y = 0; y < 32; y++)
            for (int x = 0; x < WIDTH; x++)
                read_chk("loopback_px", x, y,
                         {1'(x == y), 1'(x == 31 - y), 1'(x == 15 || x == 16)});

        // Randomized rows against the model
        for (int it = 0; it < 10; it++) begin
            int row, n;
            row = int'($urandom_range(0, 15));
            n = int'($urandom_range(WIDTH - 2, WIDTH + 2));
            if ($urandom_range(0, 1) == 1) clear_err();
            for (int c = 0; c < n; c++) pulse(6'($urandom));
            latch(row);
            check("rand_err", 32'(err_shift), 32'(m_err));
            check("rand_row_last", 32'(row_last), 32'(row));
            check("rand_frame_cnt", 32'(frame_cnt), 32'(m_frames & 255));
            for (int k = 0; k < 6; k++) begin
                int x, y;
                x = int'($urandom_range(0, 31));
                y = row + 16 * int'($urandom_range(0, 1));
                read_chk("rand_px", x, y, m_pix[y][x]);
            end
        end

        // Collision: STB and PANEL_CLK rise in the same sample
        clear_err();
        for (int c = 0; c < WIDTH; c++) pulse(6'($urandom));
        tick();
        d = 6'h2D;
        {r1, g1, b1, r0, g0, b0} = d;
        {pd, pc, pb, pa} = 4'd9;
        pclk = 1'b1; pstb = 1'b1; tick();
        pclk = 1'b0; pstb = 1'b0; tick();
        model_latch(9);
        model_shift(d);
        check("collide_err", 32'(err_shift), 0);
        row_chk("collide_row", 9);
        for (int c = 0; c < WIDTH - 1; c++) pulse(6'($urandom));
        latch(10);
        check("collide_count_err", 32'(err_shift), 0);
        row_chk("collide_next_row", 10);

        // Reset mid-row, asynchronous to clk
        for (int c = 0; c < 5; c++) pulse(6'h3F);
        latch(2);
        check("pre_rst_err", 32'(err_shift), 1);
        read_chk("pre_rst_rd", 31, 2, 3'b111);
        for (int c = 0; c < 10; c++) pulse(6'($urandom));
        d = 6'h21;
        {r1, g1, b1, r0, g0, b0} = d;
        pclk = 1'b1;
        tick();
        #2 rst = 1'b1;
        #1;
        check("async_rd_rgb", 32'(rd_rgb), 0);
        check("async_frame_pulse", 32'(frame_pulse), 0);
        check("async_frame_cnt", 32'(frame_cnt), 0);
        check("async_row_last", 32'(row_last), 15);
        check("async_oe_cycles", 32'(oe_cycles), 0);
        check("async_err", 32'(err_shift), 0);
        tick(); tick();
        rst = 1'b0;
        model_reset();
        model_shift(d);
        tick();
        for (int c = 0; c < WIDTH - 1; c++) pulse(6'($urandom));
        latch(4);
        check("post_rst_err", 32'(err_shift), 0);
        check("post_rst_row_last", 32'(row_last), 4);
        read_chk("post_rst_col0_top", 0, 4, 3'b001);
        read_chk("post_rst_col0_bot", 0, 20, 3'b100);
        row_chk("post_rst_row", 4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
